// File: rtl/conv3x3_stream.sv
// conv3x3_stream -- streaming 3x3 convolution for the camera pixel path.
//
// Takes gray pixels in raster order and produces one 3x3 window sum per
// accepted pixel. Two internal line buffers hold the previous two lines.
// Nine signed coefficients are written into a shadow file at any time. The
// shadow file is copied into the active set on each accepted start-of-frame.
// Windows that reach above row 0 or left of column 0 come out as zero with
// oBORDER set. The post-processed pixel is selected by iMODE (raw/abs/clamp).
//
// Ports
//   iCLK        clock, rising edge
//   iRST        asynchronous active-low reset
//   iDATA       unsigned input pixel (DATA_W)
//   iDVAL       input pixel valid; one pixel accepted per high cycle
//   iSOF        start of frame, qualified by iDVAL
//   iCOEF_WE    coefficient write strobe
//   iCOEF_ADDR  coefficient index 0..8 (row-major, k[0][0] = oldest row/col)
//   iCOEF_DATA  signed coefficient value (COEF_W)
//   iMODE       00 raw, 01/11 abs, 10 clamp negative to zero
//   oSUM        signed full-precision window sum (DATA_W+COEF_W+4)
//   oPIX        post-processed pixel saturated to 0..2^DATA_W-1
//   oBORDER     result comes from an incomplete window
//   oDVAL       one-cycle pulse, three cycles after the pixel was accepted
module conv3x3_stream #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 640,
  parameter int COEF_W = 4
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic [DATA_W-1:0]        iDATA,
  input  logic                     iDVAL,
  input  logic                     iSOF,
  input  logic                     iCOEF_WE,
  input  logic [3:0]               iCOEF_ADDR,
  input  logic [COEF_W-1:0]        iCOEF_DATA,
  input  logic [1:0]               iMODE,
  output logic [DATA_W+COEF_W+3:0] oSUM,
  output logic [DATA_W-1:0]        oPIX,
  output logic                     oBORDER,
  output logic                     oDVAL
);

  localparam int SUM_W = DATA_W + COEF_W + 4;
  localparam int COL_W = $clog2(IMG_W);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << DATA_W) - 1);

  // Pixel is zero-extended to a signed value before the multiply.
  function automatic logic signed [SUM_W-1:0] mulPix(input logic [DATA_W-1:0] pix,
                                                     input logic signed [COEF_W-1:0] k);
    logic signed [DATA_W:0]  p;
    logic signed [SUM_W-1:0] pe;
    logic signed [SUM_W-1:0] ke;
    p  = signed'({1'b0, pix});
    pe = SUM_W'(p);
    ke = SUM_W'(k);
    return pe * ke;
  endfunction

  // mode[0] selects abs (01 and 11); raw and clamp both saturate to 0..max.
  function automatic logic [DATA_W-1:0] satPix(input logic signed [SUM_W-1:0] s,
                                               input logic [1:0] mode);
    logic signed [SUM_W-1:0] v;
    v = (mode[0] && (s < 0)) ? -s : s;
    if (v < 0)       return '0;
    if (v > PIX_MAX) return PIX_MAX[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  logic signed [COEF_W-1:0] coefShadow [9];
  logic signed [COEF_W-1:0] coefAct    [9];
  logic signed [COEF_W-1:0] coefUse    [9];

  logic [DATA_W-1:0] lineBuf0 [IMG_W];
  logic [DATA_W-1:0] lineBuf1 [IMG_W];
  logic [DATA_W-1:0] lbRd0;
  logic [DATA_W-1:0] lbRd1;

  logic [COL_W-1:0] colCnt;
  logic [1:0]       rowCnt;   // saturates at 2; only "row < 2" matters
  logic [COL_W-1:0] curCol;
  logic [1:0]       curRow;
  logic             sofAcc;
  logic             isBorder;

  logic [DATA_W-1:0] winNext [3][3];
  logic [DATA_W-1:0] win_p1  [3][3];
  logic signed [SUM_W-1:0] prod_p1 [9];
  logic                    border_p1;
  logic                    vld_p1;
  logic signed [SUM_W-1:0] treeSum;
  logic signed [SUM_W-1:0] sum_p2;
  logic                    border_p2;
  logic                    vld_p2;

  // An accepted iSOF forces this pixel to (row 0, col 0).
  assign sofAcc   = iDVAL & iSOF;
  assign curCol   = sofAcc ? '0 : colCnt;
  assign curRow   = sofAcc ? '0 : rowCnt;
  assign isBorder = (curRow < 2'd2) || (curCol < COL_W'(2));
  assign lbRd0    = lineBuf0[curCol];
  assign lbRd1    = lineBuf1[curCol];

  // The frame's first pixel uses the shadow set it is about to activate.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      coefUse[i] = sofAcc ? coefShadow[i] : coefAct[i];
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        winNext[r][c] = sofAcc ? '0 : win_p1[r][c+1];
      end
    end
    winNext[0][2] = lbRd1;
    winNext[1][2] = lbRd0;
    winNext[2][2] = iDATA;
  end

  always_comb begin
    treeSum = '0;
    for (int i = 0; i < 9; i++) begin
      treeSum = treeSum + prod_p1[i];
    end
  end

  always_ff @(posedge iCLK) begin
    // stage 1: line buffers, window shift, products
    if (iDVAL) begin
      lineBuf0[curCol] <= iDATA;
      lineBuf1[curCol] <= lbRd0;
      win_p1           <= winNext;
    end
    for (int i = 0; i < 9; i++) begin
      prod_p1[i] <= mulPix(winNext[i/3][i%3], coefUse[i]);
    end
    border_p1 <= isBorder;
    // stage 2: adder tree, border zeroing
    sum_p2    <= border_p1 ? '0 : treeSum;
    border_p2 <= border_p1;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      colCnt  <= '0;
      rowCnt  <= '0;
      for (int i = 0; i < 9; i++) begin
        coefShadow[i] <= (i == 4) ? COEF_W'(1) : '0;
        coefAct[i]    <= (i == 4) ? COEF_W'(1) : '0;
      end
      oSUM    <= '0;
      oPIX    <= '0;
      oBORDER <= 1'b0;
      oDVAL   <= 1'b0;
    end else begin
      vld_p1 <= iDVAL;
      vld_p2 <= vld_p1;
      if (iDVAL) begin
        if (curCol == COL_LAST) begin
          colCnt <= '0;
          rowCnt <= (curRow == 2'd2) ? curRow : curRow + 2'd1;
        end else begin
          colCnt <= curCol + COL_W'(1);
          rowCnt <= curRow;
        end
      end
      if (iCOEF_WE && (iCOEF_ADDR < 4'd9)) begin
        coefShadow[iCOEF_ADDR] <= iCOEF_DATA;
      end
      if (sofAcc) begin
        coefAct <= coefShadow;
      end
      // stage 3: post-process, outputs hold between results
      oDVAL <= vld_p2;
      if (vld_p2) begin
        oSUM    <= sum_p2;
        oPIX    <= satPix(sum_p2, iMODE);
        oBORDER <= border_p2;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Testbench for conv3x3_stream with an 8-pixel line and 12-bit pixels.
module tb_conv3x3_stream;
  localparam int DATA_W = 12;
  localparam int IMG_W  = 8;
  localparam int COEF_W = 4;
  localparam int SUM_W  = DATA_W + COEF_W + 4;
  localparam int NPIX   = 64;

  logic              iCLK = 1'b0;
  logic              iRST = 1'b1;
  logic [DATA_W-1:0] iDATA = '0;
  logic              iDVAL = 1'b0;
  logic              iSOF = 1'b0;
  logic              iCOEF_WE = 1'b0;
  logic [3:0]        iCOEF_ADDR = '0;
  logic [COEF_W-1:0] iCOEF_DATA = '0;
  logic [1:0]        iMODE = 2'b00;
  logic [SUM_W-1:0]  oSUM;
  logic [DATA_W-1:0] oPIX;
  logic              oBORDER;
  logic              oDVAL;

  conv3x3_stream #(.DATA_W(DATA_W), .IMG_W(IMG_W), .COEF_W(COEF_W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
    .iCOEF_WE(iCOEF_WE), .iCOEF_ADDR(iCOEF_ADDR), .iCOEF_DATA(iCOEF_DATA),
    .iMODE(iMODE), .oSUM(oSUM), .oPIX(oPIX), .oBORDER(oBORDER), .oDVAL(oDVAL)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int nChecks = 0;
  int nErrors = 0;

  int   accCyc[$];
  int   capCyc[$];
  int   capSum[$];
  int   capPix[$];
  logic capBorder[$];

  always @(posedge iCLK) if (iDVAL && iRST) accCyc.push_back(cyc);
  always @(negedge iCLK) begin
    if (oDVAL) begin
      capCyc.push_back(cyc);
      capSum.push_back(int'($signed(oSUM)));
      capPix.push_back(int'(oPIX));
      capBorder.push_back(oBORDER);
    end
  end

  logic [DATA_W-1:0] frameBuf [NPIX];
  int   expSum [NPIX];
  int   expPix [NPIX];
  logic expBorder [NPIX];
  int   coefTbl [9];
  int   wrAt = -1;
  logic [3:0] wrAddr = '0;
  logic [COEF_W-1:0] wrData = '0;

  task automatic clearCap();
    accCyc.delete(); capCyc.delete(); capSum.delete(); capPix.delete(); capBorder.delete();
  endtask

  task automatic loadCoefs();
    for (int i = 0; i < 9; i++) begin
      iCOEF_WE = 1'b1; iCOEF_ADDR = 4'(i); iCOEF_DATA = COEF_W'(coefTbl[i]);
      @(negedge iCLK);
    end
    iCOEF_WE = 1'b0;
  endtask

  // Gaps drive junk data and a stray iSOF with iDVAL low.
  task automatic sendFrame(input bit gaps);
    for (int i = 0; i < NPIX; i++) begin
      iDATA = frameBuf[i]; iSOF = (i == 0); iDVAL = 1'b1;
      iCOEF_WE = (i == wrAt); iCOEF_ADDR = wrAddr; iCOEF_DATA = wrData;
      @(negedge iCLK);
      iDVAL = 1'b0; iSOF = 1'b0; iCOEF_WE = 1'b0;
      if (gaps && ((i % 3 == 1) || (i % 8 == 7))) begin
        iDATA = 12'hABC; iSOF = 1'b1;
        repeat ($urandom_range(5, 1)) @(negedge iCLK);
        iSOF = 1'b0;
      end
    end
  endtask

  // Identity on ramp 16*row+col: interior result is the window centre pixel.
  function automatic void fillRamp();
    for (int i = 0; i < NPIX; i++) begin
      int r = i / 8;
      int c = i % 8;
      frameBuf[i]  = DATA_W'(16 * r + c);
      expBorder[i] = (r < 2) || (c < 2);
      expSum[i]    = expBorder[i] ? 0 : 16 * (r - 1) + (c - 1);
      expPix[i]    = expSum[i];
    end
  endfunction

  function automatic void fillConst(input int pix, input int interior, input int ipix);
    for (int i = 0; i < NPIX; i++) begin
      frameBuf[i]  = DATA_W'(pix);
      expBorder[i] = (i / 8 < 2) || (i % 8 < 2);
      expSum[i]    = expBorder[i] ? 0 : interior;
      expPix[i]    = expBorder[i] ? 0 : ipix;
    end
  endfunction

  task automatic test_reset();
    iRST = 1'b1;
    #3 iRST = 1'b0;
    repeat (3) @(negedge iCLK);
    nChecks++; if (oSUM !== '0) begin nErrors++; $display("FAIL reset_oSUM: got %0d expected 0", oSUM); end
    nChecks++; if (oPIX !== '0) begin nErrors++; $display("FAIL reset_oPIX: got %0d expected 0", oPIX); end
    nChecks++; if (oBORDER !== 1'b0) begin nErrors++; $display("FAIL reset_oBORDER: got %0b expected 0", oBORDER); end
    nChecks++; if (oDVAL !== 1'b0) begin nErrors++; $display("FAIL reset_oDVAL: got %0b expected 0", oDVAL); end
    iRST = 1'b1;
    repeat (2) @(negedge iCLK);
    nChecks++; if (oDVAL !== 1'b0) begin nErrors++; $display("FAIL reset_idle_oDVAL: got %0b expected 0", oDVAL); end
  endtask

  task automatic test_identity_ramp();
    clearCap(); fillRamp(); iMODE = 2'b00; wrAt = -1;
    sendFrame(1'b0);
    repeat (8) @(negedge iCLK);
    nChecks++; if (capSum.size() !== NPIX) begin nErrors++; $display("FAIL ramp_count: got %0d expected %0d", capSum.size(), NPIX); end
    if (capSum.size() == NPIX && accCyc.size() == NPIX) begin
      nChecks++; if (capSum[28] !== 35) begin nErrors++; $display("FAIL ramp_r3c4_sum: got %0d expected 35", capSum[28]); end
      nChecks++; if (capCyc[28] - accCyc[28] !== 3) begin nErrors++; $display("FAIL ramp_r3c4_latency: got %0d expected 3", capCyc[28] - accCyc[28]); end
      for (int i = 0; i < NPIX; i++) begin
        nChecks++; if (capSum[i] !== expSum[i]) begin nErrors++; $display("FAIL ramp_sum[%0d]: got %0d expected %0d", i, capSum[i], expSum[i]); end
        nChecks++; if (capPix[i] !== expPix[i]) begin nErrors++; $display("FAIL ramp_pix[%0d]: got %0d expected %0d", i, capPix[i], expPix[i]); end
        nChecks++; if (capBorder[i] !== expBorder[i]) begin nErrors++; $display("FAIL ramp_border[%0d]: got %0b expected %0b", i, capBorder[i], expBorder[i]); end
      end
    end
  endtask

  // Step edge under Sobel-X: interior sum = 4*(p[c]-p[c-2]).
  task automatic test_sobel();
    int stepSum [8];
    stepSum = '{0, 0, 0, 0, 16380, 16380, 0, 0};
    coefTbl = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    loadCoefs();
    for (int v = 0; v < 3; v++) begin
      int sgn = (v == 0) ? 1 : -1;
      iMODE = (v == 2) ? 2'b11 : 2'b00;
      for (int i = 0; i < NPIX; i++) begin
        int c = i % 8;
        frameBuf[i]  = ((c >= 4) == (v == 0)) ? 12'd4095 : 12'd0;
        expBorder[i] = (i / 8 < 2) || (c < 2);
        expSum[i]    = expBorder[i] ? 0 : sgn * stepSum[c];
        expPix[i]    = (expSum[i] == 0) ? 0 : ((sgn > 0 || v == 2) ? 4095 : 0);
      end
      clearCap();
      sendFrame(1'b0);
      repeat (8) @(negedge iCLK);
      nChecks++; if (capSum.size() !== NPIX) begin nErrors++; $display("FAIL sobel%0d_count: got %0d expected %0d", v, capSum.size(), NPIX); end
      if (capSum.size() == NPIX) begin
        for (int i = 0; i < NPIX; i++) begin
          nChecks++; if (capSum[i] !== expSum[i]) begin nErrors++; $display("FAIL sobel%0d_sum[%0d]: got %0d expected %0d", v, i, capSum[i], expSum[i]); end
          nChecks++; if (capPix[i] !== expPix[i]) begin nErrors++; $display("FAIL sobel%0d_pix[%0d]: got %0d expected %0d", v, i, capPix[i], expPix[i]); end
        end
      end
    end
  endtask

  task automatic test_constant();
    for (int v = 0; v < 2; v++) begin
      if (v == 0) begin
        iMODE = 2'b00; fillConst(100, 0, 0);
      end else begin
        coefTbl = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
        loadCoefs();
        iMODE = 2'b10; fillConst(4095, 257985, 4095);
      end
      clearCap();
      sendFrame(1'b0);
      repeat (8) @(negedge iCLK);
      nChecks++; if (capSum.size() !== NPIX) begin nErrors++; $display("FAIL const%0d_count: got %0d expected %0d", v, capSum.size(), NPIX); end
      if (capSum.size() == NPIX) begin
        for (int i = 0; i < NPIX; i++) begin
          nChecks++; if (capSum[i] !== expSum[i]) begin nErrors++; $display("FAIL const%0d_sum[%0d]: got %0d expected %0d", v, i, capSum[i], expSum[i]); end
          nChecks++; if (capPix[i] !== expPix[i]) begin nErrors++; $display("FAIL const%0d_pix[%0d]: got %0d expected %0d", v, i, capPix[i], expPix[i]); end
          nChecks++; if (capBorder[i] !== expBorder[i]) begin nErrors++; $display("FAIL const%0d_border[%0d]: got %0b expected %0b", v, i, capBorder[i], expBorder[i]); end
        end
      end
    end
  endtask

  // Frames of constant 10. Frame 0 writes k11=-8 mid-frame; frame 1 writes
  // address 9 (ignored); frame 2 writes k11=1 together with its iSOF.
  task automatic test_coef_midframe();
    int tAt   [4];
    int tAddr [4];
    int tData [4];
    int tMode [4];
    int tSum  [4];
    int tPix  [4];
    tAt = '{20, 5, 0, -1}; tAddr = '{4, 9, 4, 0}; tData = '{-8, 7, 1, 0};
    tMode = '{0, 0, 1, 0}; tSum = '{10, -80, -80, 10}; tPix = '{10, 0, 80, 10};
    coefTbl = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    loadCoefs();
    for (int v = 0; v < 4; v++) begin
      wrAt = tAt[v]; wrAddr = 4'(tAddr[v]); wrData = COEF_W'(tData[v]);
      iMODE = 2'(tMode[v]);
      fillConst(10, tSum[v], tPix[v]);
      clearCap();
      sendFrame(1'b0);
      wrAt = -1;
      repeat (8) @(negedge iCLK);
      nChecks++; if (capSum.size() !== NPIX) begin nErrors++; $display("FAIL coef%0d_count: got %0d expected %0d", v, capSum.size(), NPIX); end
      if (capSum.size() == NPIX) begin
        for (int i = 0; i < NPIX; i++) begin
          nChecks++; if (capSum[i] !== expSum[i]) begin nErrors++; $display("FAIL coef%0d_sum[%0d]: got %0d expected %0d", v, i, capSum[i], expSum[i]); end
          nChecks++; if (capPix[i] !== expPix[i]) begin nErrors++; $display("FAIL coef%0d_pix[%0d]: got %0d expected %0d", v, i, capPix[i], expPix[i]); end
        end
      end
    end
  endtask

  task automatic test_gaps();
    clearCap(); fillRamp(); iMODE = 2'b00; wrAt = -1;
    sendFrame(1'b1);
    repeat (8) @(negedge iCLK);
    nChecks++; if (accCyc.size() !== NPIX) begin nErrors++; $display("FAIL gaps_accept_count: got %0d expected %0d", accCyc.size(), NPIX); end
    nChecks++; if (capSum.size() !== NPIX) begin nErrors++; $display("FAIL gaps_dval_count: got %0d expected %0d", capSum.size(), NPIX); end
    if (capSum.size() == NPIX && accCyc.size() == NPIX) begin
      for (int i = 0; i < NPIX; i++) begin
        nChecks++; if (capSum[i] !== expSum[i]) begin nErrors++; $display("FAIL gaps_sum[%0d]: got %0d expected %0d", i, capSum[i], expSum[i]); end
        nChecks++; if (capBorder[i] !== expBorder[i]) begin nErrors++; $display("FAIL gaps_border[%0d]: got %0b expected %0b", i, capBorder[i], expBorder[i]); end
        nChecks++; if (capCyc[i] - accCyc[i] !== 3) begin nErrors++; $display("FAIL gaps_latency[%0d]: got %0d expected 3", i, capCyc[i] - accCyc[i]); end
      end
    end
  endtask

  // Reset lands right after pixel 11 is accepted; pixels 0..8 have already
  // produced results, pixels 9..11 are still in the pipeline.
  task automatic test_midreset();
    int nBefore;
    coefTbl = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    loadCoefs();
    clearCap(); iMODE = 2'b00;
    for (int i = 0; i < 12; i++) begin
      iDATA = DATA_W'(16 * (i / 8) + (i % 8)); iSOF = (i == 0); iDVAL = 1'b1;
      if (i < 11) begin
        @(negedge iCLK);
      end else begin
        @(posedge iCLK);
        #1 iRST = 1'b0; iDVAL = 1'b0; iSOF = 1'b0;
      end
    end
    nBefore = capSum.size();
    nChecks++; if (nBefore !== 9) begin nErrors++; $display("FAIL midrst_pre_count: got %0d expected 9", nBefore); end
    @(negedge iCLK);
    nChecks++; if (oSUM !== '0) begin nErrors++; $display("FAIL midrst_oSUM: got %0d expected 0", oSUM); end
    nChecks++; if (oPIX !== '0) begin nErrors++; $display("FAIL midrst_oPIX: got %0d expected 0", oPIX); end
    nChecks++; if (oBORDER !== 1'b0) begin nErrors++; $display("FAIL midrst_oBORDER: got %0b expected 0", oBORDER); end
    nChecks++; if (oDVAL !== 1'b0) begin nErrors++; $display("FAIL midrst_oDVAL: got %0b expected 0", oDVAL); end
    repeat (2) @(negedge iCLK);
    iRST = 1'b1;
    repeat (6) @(negedge iCLK);
    nChecks++; if (capSum.size() !== nBefore) begin nErrors++; $display("FAIL midrst_flush: got %0d results expected %0d", capSum.size(), nBefore); end
    // Coefficients are back to identity: the ramp must match the identity golden.
    clearCap(); fillRamp();
    sendFrame(1'b0);
    repeat (8) @(negedge iCLK);
    nChecks++; if (capSum.size() !== NPIX) begin nErrors++; $display("FAIL midrst_post_count: got %0d expected %0d", capSum.size(), NPIX); end
    if (capSum.size() == NPIX) begin
      for (int i = 0; i < NPIX; i++) begin
        nChecks++; if (capSum[i] !== expSum[i]) begin nErrors++; $display("FAIL midrst_post_sum[%0d]: got %0d expected %0d", i, capSum[i], expSum[i]); end
        nChecks++; if (capBorder[i] !== expBorder[i]) begin nErrors++; $display("FAIL midrst_post_border[%0d]: got %0b expected %0b", i, capBorder[i], expBorder[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity_ramp();
    test_sobel();
    test_constant();
    test_coef_midframe();
    test_gaps();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
